// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU feeding a credit-guarded result queue.
// Define ALU_MUL_EN to add the MUL/MULH/MULHSU/MULHU datapath.
`ifndef OPT_LUI
`define OPT_LUI    6'd1
`define OPT_AUIPC  6'd2
`define OPT_JAL    6'd3
`define OPT_JALR   6'd4
`define OPT_BEQ    6'd5
`define OPT_BNE    6'd6
`define OPT_BLT    6'd7
`define OPT_BGE    6'd8
`define OPT_BLTU   6'd9
`define OPT_BGEU   6'd10
`define OPT_ADDI   6'd11
`define OPT_SLTI   6'd12
`define OPT_SLTIU  6'd13
`define OPT_XORI   6'd14
`define OPT_ORI    6'd15
`define OPT_ANDI   6'd16
`define OPT_SLLI   6'd17
`define OPT_SRLI   6'd18
`define OPT_SRAI   6'd19
`define OPT_ADD    6'd20
`define OPT_SUB    6'd21
`define OPT_SLL    6'd22
`define OPT_SLT    6'd23
`define OPT_SLTU   6'd24
`define OPT_XOR    6'd25
`define OPT_SRL    6'd26
`define OPT_SRA    6'd27
`define OPT_OR     6'd28
`define OPT_AND    6'd29
`define OPT_MUL    6'd30
`define OPT_MULH   6'd31
`define OPT_MULHSU 6'd32
`define OPT_MULHU  6'd33
`endif

module alu_pipe #(
  parameter int XLEN       = 32,
  parameter int ROB_IDX_W  = 4,
  parameter int OPT_W      = 6,
  parameter int STAGES     = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPT_W-1:0]     in_opt,
  input  logic [XLEN-1:0]      in_val1,
  input  logic [XLEN-1:0]      in_val2,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  output logic [XLEN-1:0]      out_val,
  output logic                 out_tk
);

  localparam int AW = $clog2(OBUF_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      val;
    logic                 tk;
  } res_t;

  logic [XLEN-1:0] val;
  logic            tk;
  logic [4:0]      shv;
  logic [4:0]      shi;
  res_t            res;
  res_t            wr_data;
  res_t            head;
  logic            wr_en;
  logic            acc;
  logic            pop;
  logic [CW-1:0]   credit;
  logic [CW-1:0]   wptr;
  logic [CW-1:0]   rptr;
  res_t            mem [OBUF_DEPTH];

  assign shv = in_val2[4:0];
  assign shi = in_imm[4:0];

`ifdef ALU_MUL_EN
  logic              s1;
  logic              s2;
  logic [2*XLEN-1:0] ma;
  logic [2*XLEN-1:0] mb;
  logic [2*XLEN-1:0] prod;

  // Sign-extend operands per variant so one product serves all four ops
  always_comb begin
    s1   = (in_opt == `OPT_MULH) || (in_opt == `OPT_MULHSU);
    s2   = (in_opt == `OPT_MULH);
    ma   = {{XLEN{s1 & in_val1[XLEN-1]}}, in_val1};
    mb   = {{XLEN{s2 & in_val2[XLEN-1]}}, in_val2};
    prod = ma * mb;
  end
`endif

  // Result and branch flag computed in the accept cycle
  always_comb begin
    val = '0;
    tk  = 1'b0;
    case (in_opt)
      `OPT_LUI, `OPT_AUIPC,
      `OPT_JALR, `OPT_ADDI: val = in_val1 + in_imm;
      `OPT_JAL, `OPT_ADD:   val = in_val1 + in_val2;
      `OPT_SUB:   val = in_val1 - in_val2;
      `OPT_AND:   val = in_val1 & in_val2;
      `OPT_OR:    val = in_val1 | in_val2;
      `OPT_XOR:   val = in_val1 ^ in_val2;
      `OPT_ANDI:  val = in_val1 & in_imm;
      `OPT_ORI:   val = in_val1 | in_imm;
      `OPT_XORI:  val = in_val1 ^ in_imm;
      `OPT_SLL:   val = in_val1 << shv;
      `OPT_SRL:   val = in_val1 >> shv;
      `OPT_SRA:   val = $unsigned($signed(in_val1) >>> shv);
      `OPT_SLLI:  val = in_val1 << shi;
      `OPT_SRLI:  val = in_val1 >> shi;
      `OPT_SRAI:  val = $unsigned($signed(in_val1) >>> shi);
      `OPT_SLT:
        val = {{(XLEN-1){1'b0}},
               $signed(in_val1) < $signed(in_val2)};
      `OPT_SLTI:
        val = {{(XLEN-1){1'b0}},
               $signed(in_val1) < $signed(in_imm)};
      `OPT_SLTU:
        val = {{(XLEN-1){1'b0}}, in_val1 < in_val2};
      `OPT_SLTIU:
        val = {{(XLEN-1){1'b0}}, in_val1 < in_imm};
      `OPT_BEQ:   tk = in_val1 == in_val2;
      `OPT_BNE:   tk = in_val1 != in_val2;
      `OPT_BLT:   tk = $signed(in_val1) < $signed(in_val2);
      `OPT_BGE:   tk = $signed(in_val1) >= $signed(in_val2);
      `OPT_BLTU:  tk = in_val1 < in_val2;
      `OPT_BGEU:  tk = in_val1 >= in_val2;
`ifdef ALU_MUL_EN
      `OPT_MUL:   val = prod[XLEN-1:0];
      `OPT_MULH, `OPT_MULHSU,
      `OPT_MULHU: val = prod[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
  end

  assign res = {in_rob_idx, val, tk};

  assign in_ready = rst && rdy && !flush &&
                    (credit < CW'(OBUF_DEPTH));
  assign acc = in_valid && in_ready &&
               (in_rob_idx != '0);
  assign head        = mem[rptr[AW-1:0]];
  assign out_valid   = rdy && (wptr != rptr);
  assign pop         = out_valid && out_ready;
  assign out_rob_idx = head.rob_idx;
  assign out_val     = head.val;
  assign out_tk      = head.tk;

  if (STAGES > 1) begin : g_pipe
    logic [STAGES-2:0] sv;
    res_t              sd [STAGES-1];

    // Carry accepted results through the valid-tagged stages
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sv <= '0;
        for (int i = 0; i < STAGES - 1; i++)
          sd[i] <= '0;
      end else if (rdy) begin
        if (flush) begin
          sv <= '0;
        end else begin
          sv[0] <= acc;
          sd[0] <= res;
          for (int i = 1; i < STAGES - 1; i++) begin
            sv[i] <= sv[i-1];
            sd[i] <= sd[i-1];
          end
        end
      end
    end

    assign wr_en   = sv[STAGES-2];
    assign wr_data = sd[STAGES-2];
  end else begin : g_direct
    assign wr_en   = acc;
    assign wr_data = res;
  end

  // Result queue; flush drops queued entries by rewinding pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++)
        mem[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_en) begin
          mem[wptr[AW-1:0]] <= wr_data;
          wptr <= wptr + CW'(1);
        end
        if (pop)
          rptr <= rptr + CW'(1);
      end
    end
  end

  // Credit tracks pipeline plus queue occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= '0;
    end else if (rdy) begin
      if (flush)
        credit <= '0;
      else if (acc && !pop)
        credit <= credit + CW'(1);
      else if (!acc && pop)
        credit <= credit - CW'(1);
    end
  end

endmodule
